mc_sequencer: RTL

- Parametrised multi-cycle instruction sequencer for the MIPS core; successor to the fixed-wait control FSM.
- Drives enables for memory, decoder, register file, ALU, branch and jump units.
- Sequences FETCH → DECODE → per-path stages → retire, using done-handshakes with per-wait timeouts.
- Configurable memory wait states; retire counter and fault trap; one-hot stage indicators for the board LEDs.

---
 rtl/mc_seq_pkg.sv | 61 ++++++
 rtl/seq_wait_timer.sv | 34 +++
 rtl/mc_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_seq_pkg
// Description : Shared types and constants for the multi-cycle sequencer:
//               state encoding, decoder path indices, stage LED bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_FWAIT  = 4'd2,
    S_DECODE = 4'd3,
    S_REGRD  = 4'd4,
    S_EXEC   = 4'd5,
    S_MEMACC = 4'd6,
    S_MWAIT  = 4'd7,
    S_WB     = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd11
  } state_e;

  // Decoder path indices; anything above PATH_JUMP is illegal.
  localparam int PATH_ALUR   = 0;
  localparam int PATH_ALUI   = 1;
  localparam int PATH_LOAD   = 2;
  localparam int PATH_STORE  = 3;
  localparam int PATH_BRANCH = 4;
  localparam int PATH_JUMP   = 5;

  // Bit positions inside the one-hot stage vector {BR,JU,WB,MEM,EX,ID,IF}.
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int STG_JU  = 5;
  localparam int STG_BR  = 6;
  localparam int STG_W   = 7;

  // Map a state to its board-LED stage indicator (zero in IDLE and TRAP).
  function automatic logic [STG_W-1:0] stage_onehot(input state_e s);
    logic [STG_W-1:0] v;
    v = '0;
    case (s)
      S_FETCH, S_FWAIT:  v[STG_IF]  = 1'b1;
      S_DECODE, S_REGRD: v[STG_ID]  = 1'b1;
      S_EXEC:            v[STG_EX]  = 1'b1;
      S_MEMACC, S_MWAIT: v[STG_MEM] = 1'b1;
      S_WB:              v[STG_WB]  = 1'b1;
      S_JUMP:            v[STG_JU]  = 1'b1;
      S_BRANCH:          v[STG_BR]  = 1'b1;
      default:           v = '0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_wait_timer
// Description : Loadable down-counter. Loaded with (N-1) on state entry, it
//               reports expired on the N-th cycle spent in that state.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // Reload on entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mc_sequencer
// Description : Multi-cycle MIPS instruction sequencer. FETCH -> DECODE ->
//               path stages -> retire, with done handshakes, per-wait
//               timeouts, configurable memory wait states and a fault trap.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_sequencer
  import mc_seq_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int TIMEOUT  = 255,
  parameter int PATH_W   = 4,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              top_en,
  input  logic              dec_done,
  input  logic [PATH_W-1:0] dec_path,
  input  logic              reg_done,
  input  logic              alu_done,
  input  logic              br_done,
  input  logic              jmp_done,
  output logic              mem_en,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic              dec_en,
  output logic              reg_en,
  output logic              reg_we,
  output logic              alu_en,
  output logic              br_en,
  output logic              jmp_en,
  output logic              pc_we,
  output logic [STG_W-1:0]  stage,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic              fault,
  output logic              busy
);

  // One timer serves both the fixed memory waits and the done timeouts.
  localparam int TMAX = (TIMEOUT > MEM_WAIT) ? TIMEOUT : MEM_WAIT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] MW_LOAD = TW'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [PATH_W-1:0]   path_q, path_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                retire;
  logic                tmr_load, tmr_expired;
  logic [TW-1:0]       tmr_val;
  logic                mem_en_q, mem_ren_q, mem_wen_q, dec_en_q, reg_en_q;
  logic                reg_we_q, alu_en_q, br_en_q, jmp_en_q, fault_q, busy_q;
  logic [STG_W-1:0]    stage_q;
  logic                is_store, load_d, store_d;

  assign is_store = (path_q == PATH_W'(PATH_STORE));
  assign load_d   = (path_d == PATH_W'(PATH_LOAD));
  assign store_d  = (path_d == PATH_W'(PATH_STORE));

  // Next-state, path capture and retire detection.
  always_comb begin
    state_d = state_q;
    path_d  = path_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (top_en) state_d = S_FETCH;
      S_FETCH:  state_d = (MEM_WAIT == 0) ? S_DECODE : S_FWAIT;
      S_FWAIT:  if (tmr_expired) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_done) begin
          path_d = dec_path;
          if (dec_path == PATH_W'(PATH_JUMP))        state_d = S_JUMP;
          else if (dec_path <= PATH_W'(PATH_BRANCH)) state_d = S_REGRD;
          else                                       state_d = S_TRAP;
        end else if (tmr_expired) begin
          state_d = S_TRAP;
        end
      end
      S_REGRD: begin
        if (reg_done)         state_d = S_EXEC;
        else if (tmr_expired) state_d = S_TRAP;
      end
      S_EXEC: begin
        if (alu_done) begin
          case (path_q)
            PATH_W'(PATH_ALUR), PATH_W'(PATH_ALUI):  state_d = S_WB;
            PATH_W'(PATH_LOAD), PATH_W'(PATH_STORE): state_d = S_MEMACC;
            PATH_W'(PATH_BRANCH):                    state_d = S_BRANCH;
            default:                                 state_d = S_TRAP;
          endcase
        end else if (tmr_expired) begin
          state_d = S_TRAP;
        end
      end
      S_MEMACC: begin
        if (MEM_WAIT != 0) state_d = S_MWAIT;
        else if (is_store) retire  = 1'b1;
        else               state_d = S_WB;
      end
      S_MWAIT: begin
        if (tmr_expired) begin
          if (is_store) retire  = 1'b1;
          else          state_d = S_WB;
        end
      end
      S_WB:     retire = 1'b1;
      S_BRANCH: begin
        if (br_done)          retire  = 1'b1;
        else if (tmr_expired) state_d = S_TRAP;
      end
      S_JUMP: begin
        if (jmp_done)         retire  = 1'b1;
        else if (tmr_expired) state_d = S_TRAP;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    if (retire) state_d = top_en ? S_FETCH : S_IDLE;
  end

  // Every state change reloads the timer for the state being entered.
  assign tmr_load = (state_d != state_q);
  assign tmr_val  = (state_d == S_FWAIT || state_d == S_MWAIT) ? MW_LOAD : TO_LOAD;

  seq_wait_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // State, retire counter and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      path_q    <= '0;
      cnt_q     <= '0;
      mem_en_q  <= 1'b0;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      dec_en_q  <= 1'b0;
      reg_en_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      alu_en_q  <= 1'b0;
      br_en_q   <= 1'b0;
      jmp_en_q  <= 1'b0;
      fault_q   <= 1'b0;
      busy_q    <= 1'b0;
      stage_q   <= '0;
    end else begin
      state_q   <= state_d;
      path_q    <= path_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
      mem_en_q  <= state_d inside {S_FETCH, S_FWAIT, S_MEMACC, S_MWAIT};
      mem_ren_q <= (state_d inside {S_FETCH, S_FWAIT}) ||
                   ((state_d inside {S_MEMACC, S_MWAIT}) && load_d);
      mem_wen_q <= (state_d inside {S_MEMACC, S_MWAIT}) && store_d;
      dec_en_q  <= (state_d == S_DECODE);
      reg_en_q  <= (state_d == S_REGRD) || (state_d == S_WB);
      reg_we_q  <= (state_d == S_WB);
      alu_en_q  <= (state_d == S_EXEC);
      br_en_q   <= (state_d == S_BRANCH);
      jmp_en_q  <= (state_d == S_JUMP);
      fault_q   <= (state_d == S_TRAP);
      busy_q    <= !(state_d inside {S_IDLE, S_TRAP});
      stage_q   <= stage_onehot(state_d);
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign dec_en    = dec_en_q;
  assign reg_en    = reg_en_q;
  assign reg_we    = reg_we_q;
  assign alu_en    = alu_en_q;
  assign br_en     = br_en_q;
  assign jmp_en    = jmp_en_q;
  assign fault     = fault_q;
  assign busy      = busy_q;
  assign stage     = stage_q;
  assign instr_cnt = cnt_q;
  // The PC strobe marks the retire cycle itself, so it follows the done input.
  assign pc_we     = retire;

endmodule
`default_nettype wire
